// File: rtl/sram_sdi_target.sv
// Serial SRAM (23LC1024-style) target for SPI/SDI busses, oversampled in the clk domain.
// Backed by an external byte-wide RAM through a one-clock-latency read port.
module sram_sdi_target #(
  parameter int ADDRBITS = 17
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sck,
  input  logic                cs,
  input  logic [1:0]          d_in,
  output logic [1:0]          d_out,
  output logic [1:0]          d_oe,
  output logic                sdi_mode,
  output logic [ADDRBITS-1:0] mem_addr,
  output logic                mem_we,
  output logic [7:0]          mem_wdata,
  output logic                mem_re,
  input  logic [7:0]          mem_rdata
);

  // state     | meaning
  // ST_IDLE   | cs high (or not yet re-armed after reset), waiting for cs fall
  // ST_CMD    | shifting in the 8-bit command
  // ST_ADDR   | shifting in the 24-bit address
  // ST_DUMMY  | SDI read dummy byte, first data pair goes out on its last fall
  // ST_RDATA  | streaming read bytes out on sck falls
  // ST_WDATA  | assembling write bytes on sck rises
  // ST_IGNORE | unsupported or mode command, bus idle until cs high
  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA, ST_IGNORE
  } state_t;

  state_t state_q, state_d;

  logic sck_s1_q, sck_s2_q, sck_prev_q;
  logic cs_s1_q, cs_s2_q, cs_prev_q;
  logic [1:0] d_s1_q, d_s2_q;

  logic [ADDRBITS-2:0] sr_q, sr_d;
  logic [ADDRBITS-1:0] sr_shift;
  logic [4:0]          cnt_q, cnt_d, cnt_inc, step;
  logic                is_read_q, is_read_d;
  logic                pend_set_q, pend_set_d, pend_clr_q, pend_clr_d;
  logic                sdi_mode_q, sdi_mode_d;
  logic [ADDRBITS-1:0] addr_q, addr_d;
  logic [7:0]          tx_q, tx_d;
  logic [1:0]          d_out_q, d_out_d, d_oe_q, d_oe_d;
  logic                we_q, we_d, re_q, re_d, re_dly_q;
  logic [7:0]          wdata_q, wdata_d;

  logic rise_ev, fall_ev, cs_rise, cs_fall;

  // Sync chains reset low so a cs already low at reset release never looks like a new select.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_prev_q <= 1'b0;
      cs_s1_q    <= 1'b0;
      cs_s2_q    <= 1'b0;
      cs_prev_q  <= 1'b0;
      d_s1_q     <= 2'b00;
      d_s2_q     <= 2'b00;
    end else begin
      sck_s1_q   <= sck;
      sck_s2_q   <= sck_s1_q;
      sck_prev_q <= sck_s2_q;
      cs_s1_q    <= cs;
      cs_s2_q    <= cs_s1_q;
      cs_prev_q  <= cs_s2_q;
      d_s1_q     <= d_in;
      d_s2_q     <= d_s1_q;
    end
  end

  assign rise_ev  = sck_s2_q & ~sck_prev_q;
  assign fall_ev  = ~sck_s2_q & sck_prev_q;
  assign cs_rise  = cs_s2_q & ~cs_prev_q;
  assign cs_fall  = ~cs_s2_q & cs_prev_q;
  assign step     = sdi_mode_q ? 5'd2 : 5'd1;
  assign cnt_inc  = cnt_q + step;
  assign sr_shift = sdi_mode_q ? {sr_q[ADDRBITS-3:0], d_s2_q} : {sr_q, d_s2_q[0]};

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (cs_fall) state_d = ST_CMD;
        ST_CMD:
          if (rise_ev && cnt_inc == 5'd8) begin
            if (sr_shift[7:0] == 8'h03 || sr_shift[7:0] == 8'h02) state_d = ST_ADDR;
            else                                                  state_d = ST_IGNORE;
          end
        ST_ADDR:
          if (rise_ev && cnt_inc == 5'd24) begin
            if (!is_read_q)      state_d = ST_WDATA;
            else if (sdi_mode_q) state_d = ST_DUMMY;
            else                 state_d = ST_RDATA;
          end
        ST_DUMMY: if (fall_ev && cnt_q == 5'd8) state_d = ST_RDATA;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    is_read_d  = is_read_q;
    pend_set_d = pend_set_q;
    pend_clr_d = pend_clr_q;
    sdi_mode_d = sdi_mode_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    d_out_d    = d_out_q;
    d_oe_d     = d_oe_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    wdata_d    = wdata_q;
    if (we_q)     addr_d = addr_q + 1'b1;
    if (re_dly_q) tx_d   = mem_rdata;
    if (cs_rise) begin
      d_oe_d     = 2'b00;
      cnt_d      = 5'd0;
      pend_set_d = 1'b0;
      pend_clr_d = 1'b0;
      if (pend_set_q)      sdi_mode_d = 1'b1;
      else if (pend_clr_q) sdi_mode_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:
          if (cs_fall) cnt_d = 5'd0;
        ST_CMD:
          if (rise_ev) begin
            sr_d  = sr_shift[ADDRBITS-2:0];
            cnt_d = cnt_inc;
            if (cnt_inc == 5'd8) begin
              cnt_d = 5'd0;
              case (sr_shift[7:0])
                8'h03:   is_read_d = 1'b1;
                8'h02:   is_read_d = 1'b0;
                8'h3B:   begin pend_set_d = 1'b1; pend_clr_d = 1'b0; end
                8'hFF:   begin pend_clr_d = 1'b1; pend_set_d = 1'b0; end
                default: ;
              endcase
            end
          end
        ST_ADDR:
          if (rise_ev) begin
            sr_d  = sr_shift[ADDRBITS-2:0];
            cnt_d = cnt_inc;
            if (cnt_inc == 5'd24) begin
              cnt_d  = 5'd0;
              addr_d = sr_shift;
              re_d   = is_read_q;
            end
          end
        ST_DUMMY: begin
          if (rise_ev && cnt_q != 5'd8) cnt_d = cnt_inc;
          if (fall_ev && cnt_q == 5'd8) begin
            d_out_d = tx_q[7:6];
            tx_d    = {tx_q[5:0], 2'b00};
            d_oe_d  = 2'b11;
            cnt_d   = 5'd2;
          end
        end
        ST_RDATA:
          if (fall_ev) begin
            if (sdi_mode_q) begin
              d_out_d = tx_q[7:6];
              tx_d    = {tx_q[5:0], 2'b00};
              d_oe_d  = 2'b11;
            end else begin
              d_out_d = {tx_q[7], 1'b0};
              tx_d    = {tx_q[6:0], 1'b0};
              d_oe_d  = 2'b10;
            end
            cnt_d = cnt_inc;
            // Byte fully driven: fetch the next one well before the following fall.
            if (cnt_inc == 5'd8) begin
              cnt_d  = 5'd0;
              addr_d = addr_q + 1'b1;
              re_d   = 1'b1;
            end
          end
        ST_WDATA:
          if (rise_ev) begin
            sr_d  = sr_shift[ADDRBITS-2:0];
            cnt_d = cnt_inc;
            if (cnt_inc == 5'd8) begin
              cnt_d   = 5'd0;
              we_d    = 1'b1;
              wdata_d = sr_shift[7:0];
            end
          end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q       <= '0;
      cnt_q      <= 5'd0;
      is_read_q  <= 1'b0;
      pend_set_q <= 1'b0;
      pend_clr_q <= 1'b0;
      sdi_mode_q <= 1'b0;
      addr_q     <= '0;
      tx_q       <= 8'h00;
      d_out_q    <= 2'b00;
      d_oe_q     <= 2'b00;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      re_dly_q   <= 1'b0;
      wdata_q    <= 8'h00;
    end else begin
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      is_read_q  <= is_read_d;
      pend_set_q <= pend_set_d;
      pend_clr_q <= pend_clr_d;
      sdi_mode_q <= sdi_mode_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      d_out_q    <= d_out_d;
      d_oe_q     <= d_oe_d;
      we_q       <= we_d;
      re_q       <= re_d;
      re_dly_q   <= re_q;
      wdata_q    <= wdata_d;
    end
  end

  assign d_out     = d_out_q;
  assign d_oe      = d_oe_q;
  assign sdi_mode  = sdi_mode_q;
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign mem_re    = re_q;

endmodule
